// File: rtl/ec_fe12_pow_s.sv
// ---------------------------------------------------------------------------
// ec_fe12_pow_s
//   Fp12 exponentiation o = a^pow using left-to-right square-and-multiply.
//   The Fp12 multiplication is done by an external multiplier. This block
//   sends it one operand pair at a time over a stream and waits for the
//   12-beat product before it sends the next pair.
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_pow                   exponent, captured on the accepted sop input beat
//   i_pow_fe12_*            sink: base element a, 12 beats, c0 first
//   o_pow_fe12_*            source: result a^pow, 12 beats, c0 first
//   o_mul_fe12_*            source: multiplier operands, beat i = {b.ci, a.ci}
//   i_mul_fe12_*            sink: multiplier product, 12 beats, c0 first
//   Each stream carries val/rdy/dat/sop/eop/ctl.
// ---------------------------------------------------------------------------
module ec_fe12_pow_s #(
  parameter type FE_TYPE  = logic [15:0],
  parameter int  CTL_BITS = 12,
  parameter int  POW_BITS = 64
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [POW_BITS-1:0]          i_pow,
  // base element input stream
  input  logic                         i_pow_fe12_val,
  output logic                         i_pow_fe12_rdy,
  input  logic [$bits(FE_TYPE)-1:0]    i_pow_fe12_dat,
  input  logic                         i_pow_fe12_sop,
  input  logic                         i_pow_fe12_eop,
  input  logic [CTL_BITS-1:0]          i_pow_fe12_ctl,
  // result output stream
  output logic                         o_pow_fe12_val,
  input  logic                         o_pow_fe12_rdy,
  output logic [$bits(FE_TYPE)-1:0]    o_pow_fe12_dat,
  output logic                         o_pow_fe12_sop,
  output logic                         o_pow_fe12_eop,
  output logic [CTL_BITS-1:0]          o_pow_fe12_ctl,
  // operands to the multiplier
  output logic                         o_mul_fe12_val,
  input  logic                         o_mul_fe12_rdy,
  output logic [2*$bits(FE_TYPE)-1:0]  o_mul_fe12_dat,
  output logic                         o_mul_fe12_sop,
  output logic                         o_mul_fe12_eop,
  output logic [CTL_BITS-1:0]          o_mul_fe12_ctl,
  // product from the multiplier
  input  logic                         i_mul_fe12_val,
  output logic                         i_mul_fe12_rdy,
  input  logic [$bits(FE_TYPE)-1:0]    i_mul_fe12_dat,
  input  logic                         i_mul_fe12_sop,
  input  logic                         i_mul_fe12_eop,
  input  logic [CTL_BITS-1:0]          i_mul_fe12_ctl
);

  localparam int FE_W  = $bits(FE_TYPE);
  localparam int REM_W = $clog2(POW_BITS + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, SCAN, SQR_TX, SQR_RX, MUL_TX, MUL_RX, OUT
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  // exp_q is consumed from its MSB. rem_q counts how many exponent bit
  // positions are still unconsumed. The two shift together, so exp_q is
  // zero again by the time rem_q reaches zero.
  logic [POW_BITS-1:0] exp_q, exp_d;
  logic [REM_W-1:0]    rem_q, rem_d;
  logic [CTL_BITS-1:0] ctl_q, ctl_d;
  logic                set_one;

  logic [FE_W-1:0]     base_q [0:11];
  logic [FE_W-1:0]     res_q  [0:11];

  logic in_fire, out_fire, mul_tx_fire, mul_rx_fire;

  // Sop/eop/ctl returned by the multiplier carry no information for this
  // block, and beat counting ignores the input eop flag.
  logic unused_ok;
  assign unused_ok = ^{i_pow_fe12_eop, i_mul_fe12_sop, i_mul_fe12_eop, i_mul_fe12_ctl};

  // Every handshake signal is decoded from registered state only. Output
  // valids therefore never depend combinationally on a downstream rdy.
  assign i_pow_fe12_rdy = (state_q == IDLE) || (state_q == LOAD);
  assign i_mul_fe12_rdy = (state_q == SQR_RX) || (state_q == MUL_RX);

  assign o_mul_fe12_val = (state_q == SQR_TX) || (state_q == MUL_TX);
  assign o_mul_fe12_dat = {((state_q == MUL_TX) ? base_q[cnt_q] : res_q[cnt_q]), res_q[cnt_q]};
  assign o_mul_fe12_sop = o_mul_fe12_val && (cnt_q == 4'd0);
  assign o_mul_fe12_eop = o_mul_fe12_val && (cnt_q == 4'd11);
  assign o_mul_fe12_ctl = ctl_q;

  assign o_pow_fe12_val = (state_q == OUT);
  assign o_pow_fe12_dat = res_q[cnt_q];
  assign o_pow_fe12_sop = o_pow_fe12_val && (cnt_q == 4'd0);
  assign o_pow_fe12_eop = o_pow_fe12_val && (cnt_q == 4'd11);
  assign o_pow_fe12_ctl = ctl_q;

  assign in_fire     = i_pow_fe12_val && i_pow_fe12_rdy;
  assign out_fire    = o_pow_fe12_val && o_pow_fe12_rdy;
  assign mul_tx_fire = o_mul_fe12_val && o_mul_fe12_rdy;
  assign mul_rx_fire = i_mul_fe12_val && i_mul_fe12_rdy;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    rem_d   = rem_q;
    ctl_d   = ctl_q;
    set_one = 1'b0;
    case (state_q)
      IDLE, LOAD: begin
        if (in_fire) begin
          if (i_pow_fe12_sop) begin
            exp_d = i_pow;
            ctl_d = i_pow_fe12_ctl;
            rem_d = REM_W'(POW_BITS);
          end
          if (cnt_q == 4'd11) begin
            cnt_d   = 4'd0;
            state_d = SCAN;
          end else begin
            cnt_d   = cnt_q + 4'd1;
            state_d = LOAD;
          end
        end
      end
      SCAN: begin
        if (exp_q == '0) begin
          set_one = 1'b1;
          state_d = OUT;
        end else begin
          // Skip the leading zeros. The leading one needs no multiplication
          // because res already holds a.
          exp_d = exp_q << 1;
          rem_d = rem_q - REM_W'(1);
          if (exp_q[POW_BITS-1]) begin
            state_d = (rem_q == REM_W'(1)) ? OUT : SQR_TX;
          end
        end
      end
      SQR_TX, MUL_TX: begin
        if (mul_tx_fire) begin
          if (cnt_q == 4'd11) begin
            cnt_d   = 4'd0;
            state_d = (state_q == SQR_TX) ? SQR_RX : MUL_RX;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      SQR_RX, MUL_RX: begin
        if (mul_rx_fire) begin
          if (cnt_q == 4'd11) begin
            cnt_d = 4'd0;
            if ((state_q == SQR_RX) && exp_q[POW_BITS-1]) begin
              state_d = MUL_TX;
            end else begin
              exp_d   = exp_q << 1;
              rem_d   = rem_q - REM_W'(1);
              state_d = (rem_q == REM_W'(1)) ? OUT : SQR_TX;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      OUT: begin
        if (out_fire) begin
          if (cnt_q == 4'd11) begin
            cnt_d   = 4'd0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      exp_q   <= '0;
      rem_q   <= '0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      rem_q   <= rem_d;
      ctl_q   <= ctl_d;
    end
  end

  // The element buffers are datapath storage and have no reset. A new run
  // rewrites every entry before any entry is read.
  always_ff @(posedge i_clk) begin
    if (in_fire) begin
      base_q[cnt_q] <= i_pow_fe12_dat;
      res_q[cnt_q]  <= i_pow_fe12_dat;
    end else if (mul_rx_fire) begin
      res_q[cnt_q]  <= i_mul_fe12_dat;
    end else if (set_one) begin
      for (int i = 0; i < 12; i++) begin
        res_q[i] <= (i == 0) ? FE_W'(1) : '0;
      end
    end
  end

endmodule

// File: doc/ec_fe12_pow_s.md
EC_FE12_POW_S -- requirements
Module: ec_fe12_pow_s

Interface
REQ-001 Parameters: FE_TYPE, no default, base field element type; CTL_BITS, 12, stream ctl width; POW_BITS, 64, exponent width.
REQ-002 i_clk  input  1  sole clock; all state changes on rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 i_pow  input  POW_BITS  exponent; sampled on the accepted sop beat of i_pow_fe12_if.
REQ-005 i_pow_fe12_if  sink  if_axi_stream (dat $bits(FE_TYPE), ctl CTL_BITS)  base element, 12 beats, c0 first.
REQ-006 o_pow_fe12_if  source  if_axi_stream (dat $bits(FE_TYPE), ctl CTL_BITS)  result element, 12 beats, c0 first.
REQ-007 o_mul_fe12_if  source  if_axi_stream (dat 2*$bits(FE_TYPE), ctl CTL_BITS)  operands to Fp12 multiplier, beat i = {b.ci, a.ci}.
REQ-008 i_mul_fe12_if  sink  if_axi_stream (dat $bits(FE_TYPE), ctl CTL_BITS)  product from Fp12 multiplier, 12 beats, c0 first.

Function
REQ-009 Block SHALL compute o = a^pow in Fp12 by left-to-right square-and-multiply, one multiplier transaction outstanding at a time.
REQ-010 Storage SHALL be two 12-entry FE_TYPE buffers: base (input a) and res (accumulator), plus exponent shift register and 4-bit beat counter.
REQ-011 FSM states SHALL be IDLE, LOAD, SCAN, SQR_TX, SQR_RX, MUL_TX, MUL_RX, OUT.
REQ-012 IDLE/LOAD: i_pow_fe12_if.rdy = 1 only in these states; each accepted beat writes base[cnt] and res[cnt]; sop beat latches i_pow and ctl; IDLE->LOAD on first accepted beat; 12th accepted beat -> SCAN; sop/eop flags SHALL NOT alter beat counting.
REQ-013 SCAN: pow == 0 -> res set to one (res[0]=1, res[1..11]=0), go OUT; else shift exponent left one bit per cycle until MSB set, then discard that MSB (res already = a); if no bits remain go OUT, else SQR_TX.
REQ-014 SQR_TX: stream 12 beats {res[i], res[i]}, sop on beat 0, eop on beat 11, ctl = latched ctl; val held with dat stable until rdy; then SQR_RX.
REQ-015 SQR_RX/MUL_RX: i_mul_fe12_if.rdy = 1; each beat writes res[cnt]; after 12 beats advance; returned sop/eop/ctl ignored.
REQ-016 After SQR_RX: if current exponent MSB = 1 -> MUL_TX ({base[i], res[i]}, same framing as REQ-014) then MUL_RX; else consume bit.
REQ-017 After bit consumed (post SQR_RX with bit 0 or post MUL_RX): remaining bits > 0 -> SQR_TX, else OUT.
REQ-018 OUT: stream res[0..11], sop beat 0, eop beat 11, ctl = latched ctl; val/dat held until rdy; after beat 11 accepted -> IDLE.
REQ-019 Multiplier transaction count SHALL equal (bit-length(pow) - 1) + (popcount(pow) - 1) for pow > 0; zero for pow in {0,1}.
REQ-020 Beats on i_mul_fe12_if outside SQR_RX/MUL_RX SHALL be held off (rdy = 0); beats on i_pow_fe12_if outside IDLE/LOAD held off.
REQ-021 Backpressure on any source SHALL stall only that stream; no beat dropped or duplicated.
REQ-022 Output valid SHALL not be combinationally dependent on any input rdy.

Reset
REQ-023 On i_rst_n low, asynchronously: FSM -> IDLE, counters 0, all source val/sop/eop = 0, exponent register 0; buffers need not reset.
REQ-024 Reset mid-transaction SHALL abandon it; first stream after release SHALL be computed from scratch with no residue.

Verification
REQ-025 pow=1, a=c0..c11=1..12 -> output 1..12, ctl echoed, zero multiplier transactions.
REQ-026 pow=0, any a -> output c0=1, c1..c11=0, zero multiplier transactions.
REQ-027 pow=2 -> exactly one transaction, each beat b==a==input; output equals multiplier model result.
REQ-028 pow=5 (101b) -> transactions in order SQR, SQR, MUL (base as b); result matches reference a^5 from bls12_381 pkg model.
REQ-029 pow=2^64-1 with random rdy (50%) on o_pow and o_mul, random val gaps on inputs -> 126 transactions, result matches model.
REQ-030 Assert i_rst_n low during MUL_TX beat 5 -> all val low immediately; then pow=3 run completes correctly.
